// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer and handshake controller for the NoC router input-port flit FIFO
// (DEPTH entries x WIDTH bits). The storage itself is an external register
// file with a synchronous write port and a combinational read port; this block
// owns the write/read pointers and the occupancy counter, and presents the
// head flit downstream in first-word-fall-through form.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   reset        synchronous, active-high; clears pointers and occupancy
//   in_valid     upstream flit valid
//   in_data      upstream flit
//   in_ready     FIFO can accept a flit this cycle
//   out_valid    head flit valid
//   out_data     head flit (straight from mem_d_out)
//   out_ready    downstream consumes the head flit this cycle
//   mem_wr       storage write enable
//   mem_wr_addr  storage write address (write pointer)
//   mem_d_in     storage write data (in_data)
//   mem_rd_addr  storage read address (read pointer)
//   mem_d_out    storage combinational read data
//   count        occupancy, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_THRESH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid depend only on registered state (and
// reset), never on in_valid or out_ready, so either side may wait on the
// other without forming a combinational loop. A valid source holds its data
// stable until the transfer happens.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int AF_THRESH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             mem_wr,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [WIDTH-1:0] mem_d_in,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_d_out,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C     = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    // Status is decoded from the occupancy counter only; the pointers are
    // equal both when empty and when full, so they cannot tell the two apart.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;

    // Masking in_ready with reset keeps the reset cycle from writing storage.
    assign in_ready  = ~full & ~reset;
    assign out_valid = ~empty;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign mem_wr      = push;
    assign mem_wr_addr = wr_ptr;
    assign mem_d_in    = in_data;
    assign mem_rd_addr = rd_ptr;

    // Fall-through read path: rd_ptr addresses the storage mux directly.
    assign out_data = mem_d_out;

    // Pointers are AW bits wide and DEPTH is 2**AW, so a plain increment
    // wraps DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
